// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Holds the FSM state encoding and the machine word type.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    TURN = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic  halt;
  logic  iREN;
  word_t iaddr;
  word_t iload;
  logic  ihit;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  word_t dload;
  logic  dhit;
  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  logic  ram_ack;
  logic  err;

  modport slave (
    input  halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ack,
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ack,
    input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface

// File: rtl/mem_arbiter_wait_counter.sv
// Saturating up-counter with synchronous clear; flags when the count sits at LIMIT.
// Used both for the per-access timeout and for the fetch starvation guard.
module mem_arbiter_wait_counter #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic at_limit
);

  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIM)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign at_limit = (cnt == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction fetches and data loads/stores onto one single-ported RAM.
// Registered FSM: IDLE grants, xACC drives the RAM, TURN shows the hit pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic         CLK,
  input  logic         RST,
  mem_arbiter_if.slave bus
);

  arb_state_t state;
  word_t      iload_r;
  word_t      dload_r;
  word_t      ramaddr_r;
  word_t      ramstore_r;
  logic       ihit_r;
  logic       dhit_r;
  logic       ramren_r;
  logic       ramwen_r;
  logic       err_r;

  logic in_acc;
  logic data_req;
  logic fetch_ok;
  logic force_fetch;
  logic dacc_grant;
  logic iacc_grant;
  logic wait_at_lim;
  logic starve_at_lim;

  assign in_acc      = (state == IACC) || (state == DACC);
  assign data_req    = bus.dREN || bus.dWEN;
  assign fetch_ok    = bus.iREN && !bus.halt;
  // A fetch starved for STARVE_MAX data grants jumps ahead of pending data.
  assign force_fetch = starve_at_lim && fetch_ok;
  assign dacc_grant  = (state == IDLE) && data_req && !force_fetch;
  assign iacc_grant  = (state == IDLE) && fetch_ok && !dacc_grant;

  mem_arbiter_wait_counter #(
    .LIMIT (TIMEOUT - 1)
  ) u_wait_cnt (
    .clk      (CLK),
    .rst      (RST),
    .clr      (!in_acc),
    .en       (in_acc && !bus.ram_ack),
    .at_limit (wait_at_lim)
  );

  mem_arbiter_wait_counter #(
    .LIMIT (STARVE_MAX)
  ) u_starve_cnt (
    .clk      (CLK),
    .rst      (RST),
    .clr      (iacc_grant || !bus.iREN),
    .en       (dacc_grant && bus.iREN),
    .at_limit (starve_at_lim)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      iload_r    <= '0;
      dload_r    <= '0;
      ramaddr_r  <= '0;
      ramstore_r <= '0;
      ihit_r     <= 1'b0;
      dhit_r     <= 1'b0;
      ramren_r   <= 1'b0;
      ramwen_r   <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      ihit_r <= 1'b0;
      dhit_r <= 1'b0;
      case (state)
        IDLE: begin
          // Request fields are latched here so later requester changes are ignored.
          if (dacc_grant) begin
            state      <= DACC;
            ramwen_r   <= bus.dWEN;
            ramren_r   <= !bus.dWEN;
            ramaddr_r  <= bus.daddr;
            ramstore_r <= bus.dWEN ? bus.dstore : '0;
          end else if (iacc_grant) begin
            state      <= IACC;
            ramren_r   <= 1'b1;
            ramwen_r   <= 1'b0;
            ramaddr_r  <= bus.iaddr;
            ramstore_r <= '0;
          end
        end
        IACC, DACC: begin
          if (bus.ram_ack) begin
            if (state == IACC) begin
              iload_r <= bus.ramload;
              ihit_r  <= 1'b1;
            end else begin
              if (!ramwen_r) dload_r <= bus.ramload;
              dhit_r <= 1'b1;
            end
            state      <= TURN;
            ramren_r   <= 1'b0;
            ramwen_r   <= 1'b0;
            ramaddr_r  <= '0;
            ramstore_r <= '0;
          end else if (wait_at_lim) begin
            err_r      <= 1'b1;
            state      <= TURN;
            ramren_r   <= 1'b0;
            ramwen_r   <= 1'b0;
            ramaddr_r  <= '0;
            ramstore_r <= '0;
          end
        end
        // One dead cycle lets the requester drop the request it just got a hit for.
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.iload    = iload_r;
  assign bus.ihit     = ihit_r;
  assign bus.dload    = dload_r;
  assign bus.dhit     = dhit_r;
  assign bus.ramREN   = ramren_r;
  assign bus.ramWEN   = ramwen_r;
  assign bus.ramaddr  = ramaddr_r;
  assign bus.ramstore = ramstore_r;
  assign bus.err      = err_r;

endmodule
